alu_vect_pipe: RTL

//  Pipelined, handshaked vector ALU: M independent unsigned lanes of N bits, one op per vector.

---
 rtl/alu_vect_pkg.sv | 40 ++++
 rtl/alu_vect_lane_div.sv | 58 +++++
 rtl/alu_vect_pipe.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_vect_pkg.sv
// Shared opcode, flag and divider-state definitions for the pipelined vector ALU.
// ALU_VECT_DIV_EN decides whether DIV/MOD are legal opcodes.
package alu_vect_pkg;

  typedef enum logic [3:0] {
    OP_MOV = 4'd0,
    OP_CMP = 4'd1,
    OP_ADD = 4'd2,
    OP_SUB = 4'd3,
    OP_MUL = 4'd4,
    OP_DIV = 4'd5,
    OP_XOR = 4'd6,
    OP_AND = 4'd7,
    OP_NOT = 4'd8,
    OP_MOD = 4'd9
  } op_e;

  localparam int FLAG_Z = 1;
  localparam int FLAG_C = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } div_state_e;

  function automatic logic op_is_div(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

  // Without the divider, DIV/MOD fall into the illegal-opcode handling.
  function automatic logic op_is_legal(input logic [3:0] op);
`ifdef ALU_VECT_DIV_EN
    return op <= 4'd9;
`else
    return (op <= 4'd9) && !op_is_div(op);
`endif
  endfunction

endpackage

// File: rtl/alu_vect_lane_div.sv
// One-lane N-bit restoring divider: start loads operands, each step retires one quotient bit.
// A zero divisor naturally yields quotient all ones and remainder equal to the dividend.
module alu_vect_lane_div
  import alu_vect_pkg::*;
#(
  parameter int N = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         step,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         dz
);

  logic [N-1:0] rem_q;
  logic [N-1:0] rem_d;
  logic [N-1:0] quo_q;
  logic [N-1:0] quo_d;
  logic [N-1:0] dvs_q;
  logic [N:0]   trial_s;

  // Shift the next dividend bit into the partial remainder and try to subtract.
  always_comb begin
    trial_s = {rem_q, quo_q[N-1]};
    if (trial_s >= {1'b0, dvs_q}) begin
      rem_d = N'(trial_s - {1'b0, dvs_q});
      quo_d = {quo_q[N-2:0], 1'b1};
    end else begin
      rem_d = trial_s[N-1:0];
      quo_d = {quo_q[N-2:0], 1'b0};
    end
  end

  // quo_q holds the not-yet-consumed dividend bits and fills with quotient bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else if (start) begin
      rem_q <= '0;
      quo_q <= dividend;
      dvs_q <= divisor;
    end else if (step) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign dz        = (dvs_q == '0);

endmodule

// File: rtl/alu_vect_pipe.sv
// Pipelined valid/ready vector ALU: M unsigned N-bit lanes, operand register, op, output register.
// ALU_VECT_DIV_EN adds the iterative per-lane DIV/MOD path and its sequencing FSM.
module alu_vect_pipe
  import alu_vect_pkg::*;
#(
  parameter int N = 24,
  parameter int M = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [M*N-1:0] a,
  input  logic [M*N-1:0] b,
  input  logic [3:0]     select,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [M*N-1:0] result,
  output logic [1:0]     flags,
  output logic           out_err
);

  localparam int W = M * N;

  logic         s1_valid_q;
  logic [W-1:0] s1_a_q;
  logic [W-1:0] s1_b_q;
  logic [3:0]   s1_op_q;

  logic         out_valid_q;
  logic [W-1:0] res_q;
  logic [1:0]   flags_q;
  logic         err_q;

  logic         accept_s;
  logic         out_free_s;
  logic         s1_adv_s;
  logic         fsm_idle_s;
  logic         div_fin_s;
  logic         out_load_s;

  logic [W-1:0] alu_res_s;
  logic [1:0]   alu_flags_s;
  logic         alu_err_s;
  logic [W-1:0] load_res_s;
  logic [1:0]   load_flags_s;
  logic         load_err_s;

  // in_ready sees out_ready combinationally so a full pipe can drain and refill in one cycle.
  assign out_free_s = !out_valid_q || out_ready;
  assign s1_adv_s   = s1_valid_q && fsm_idle_s && out_free_s;
  assign in_ready   = fsm_idle_s && (!s1_valid_q || s1_adv_s);
  assign accept_s   = in_valid && in_ready;
  assign out_load_s = s1_adv_s || div_fin_s;

  // Single-cycle lane operations on the S1 operands.
  always_comb begin : alu_lanes
    logic [N-1:0]   la;
    logic [N-1:0]   lb;
    logic [N-1:0]   lr;
    logic [N:0]     sum;
    logic [N:0]     dif;
    logic [2*N-1:0] prod;
    logic           z_all;
    logic           c_any;
    la        = '0;
    lb        = '0;
    lr        = '0;
    sum       = '0;
    dif       = '0;
    prod      = '0;
    z_all     = 1'b1;
    c_any     = 1'b0;
    alu_res_s = '0;
    for (int i = 0; i < M; i++) begin
      la   = s1_a_q[i*N +: N];
      lb   = s1_b_q[i*N +: N];
      sum  = {1'b0, la} + {1'b0, lb};
      dif  = {1'b0, la} - {1'b0, lb};
      prod = {{N{1'b0}}, la} * {{N{1'b0}}, lb};
      lr   = '0;
      case (s1_op_q)
        OP_MOV: lr = lb;
        OP_CMP: c_any = c_any | dif[N];
        OP_ADD: begin
          lr    = sum[N-1:0];
          c_any = c_any | sum[N];
        end
        OP_SUB: begin
          lr    = dif[N-1:0];
          c_any = c_any | dif[N];
        end
        OP_MUL: begin
          lr    = prod[N-1:0];
          c_any = c_any | (prod[2*N-1:N] != '0);
        end
        OP_XOR:  lr = la ^ lb;
        OP_AND:  lr = la & lb;
        OP_NOT:  lr = ~la;
        default: lr = '0;
      endcase
      if (s1_op_q == OP_CMP) begin
        z_all = z_all & (la == lb);
      end else begin
        z_all = z_all & (lr == '0);
      end
      alu_res_s[i*N +: N] = lr;
    end
    if (op_is_legal(s1_op_q)) begin
      alu_flags_s[FLAG_Z] = z_all;
      alu_flags_s[FLAG_C] = c_any;
      alu_err_s           = 1'b0;
    end else begin
      alu_res_s   = '0;
      alu_flags_s = 2'b00;
      alu_err_s   = 1'b1;
    end
  end

`ifdef ALU_VECT_DIV_EN
  localparam int CW = $clog2(N);

  div_state_e    state_q;
  logic [CW-1:0] cnt_q;
  logic          div_start_s;
  logic          div_step_s;
  logic [W-1:0]  quo_s;
  logic [W-1:0]  rem_s;
  logic [M-1:0]  dz_s;
  logic [W-1:0]  div_res_s;
  logic [1:0]    div_flags_s;
  logic          div_err_s;

  assign fsm_idle_s  = (state_q == IDLE);
  assign div_start_s = accept_s && op_is_div(select);
  assign div_step_s  = (state_q == DIV);
  assign div_fin_s   = (state_q == DONE) && out_free_s;

  for (genvar g = 0; g < M; g++) begin : g_lane_div
    alu_vect_lane_div #(.N(N)) u_div (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (div_start_s),
      .step      (div_step_s),
      .dividend  (a[g*N +: N]),
      .divisor   (b[g*N +: N]),
      .quotient  (quo_s[g*N +: N]),
      .remainder (rem_s[g*N +: N]),
      .dz        (dz_s[g])
    );
  end

  // Dividers load on acceptance, so DIV covers exactly N steps; DONE waits for a free output slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (div_start_s) begin
            state_q <= DIV;
            cnt_q   <= '0;
          end
        end
        DIV: begin
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(N - 1)) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_free_s) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // The DIV/MOD op stays parked in S1 while the dividers run.
  always_comb begin
    if (s1_op_q == OP_MOD) begin
      div_res_s = rem_s;
    end else begin
      div_res_s = quo_s;
    end
    div_err_s           = |dz_s;
    div_flags_s[FLAG_Z] = (div_res_s == '0);
    div_flags_s[FLAG_C] = 1'b0;
  end

  assign load_res_s   = div_fin_s ? div_res_s   : alu_res_s;
  assign load_flags_s = div_fin_s ? div_flags_s : alu_flags_s;
  assign load_err_s   = div_fin_s ? div_err_s   : alu_err_s;
`else
  assign fsm_idle_s   = 1'b1;
  assign div_fin_s    = 1'b0;
  assign load_res_s   = alu_res_s;
  assign load_flags_s = alu_flags_s;
  assign load_err_s   = alu_err_s;
`endif

  // Operand register: operands are captured only on acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= 4'd0;
    end else if (accept_s) begin
      s1_valid_q <= 1'b1;
      s1_a_q     <= a;
      s1_b_q     <= b;
      s1_op_q    <= select;
    end else if (s1_adv_s || div_fin_s) begin
      s1_valid_q <= 1'b0;
    end
  end

  // Output register holds its contents while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      res_q       <= '0;
      flags_q     <= 2'b00;
      err_q       <= 1'b0;
    end else if (out_load_s) begin
      out_valid_q <= 1'b1;
      res_q       <= load_res_s;
      flags_q     <= load_flags_s;
      err_q       <= load_err_s;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = res_q;
  assign flags     = flags_q;
  assign out_err   = err_q;

endmodule
